// File: rtl/vector_unit_pkg.sv
// Shared vector-unit types and the lane predicate mask encoding.
package vector_unit_pkg;

  // 32-bit SIMD word, viewed as one word, two 16-bit lanes or four 8-bit lanes.
  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] vect2;
    logic [3:0][7:0]  vect4;
  } vector_t;

  typedef enum logic {
    BIT16 = 1'b0,
    BIT8  = 1'b1
  } esize_t;

  typedef enum logic [2:0] {
    EQL,
    LST,
    LST_EQL,
    MIN,
    MAX
  } vcomp_operation_t;

  typedef struct packed {
    vector_t    result;
    logic [3:0] mask;
  } vbuf_entry_t;

  // Compare ops yield one predicate per lane in the lane MSB; min/max carry no predicate.
  function automatic logic [3:0] vcomp_mask(vector_t v, esize_t es, vcomp_operation_t op);
    logic [3:0] m;
    m = '0;
    case (op)
      EQL, LST, LST_EQL: begin
        if (es == BIT8) begin
          for (int unsigned i = 0; i < 4; i++) begin
            m[i] = v.vect4[i][7];
          end
        end else begin
          m = {2'b00, v.vect2[1][15], v.vect2[0][15]};
        end
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vector_result_buffer.sv
// Registered result FIFO between the SIMD comparison unit and writeback.
// Captures result plus lane mask on push, holds until the arbiter accepts it.
module vector_result_buffer
  import vector_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  vector_t          result_i,
  input  esize_t           element_size_i,
  input  vcomp_operation_t operation_i,
  input  logic             data_valid_i,
  input  logic             flush_i,
  input  logic             ready_i,
  output vector_t          result_o,
  output logic [3:0]       mask_o,
  output logic             data_valid_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  vbuf_entry_t      mem_q [DEPTH];
  vbuf_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic        full, empty, push, pop;
  vbuf_entry_t head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign pop   = !empty && ready_i;
  assign push  = data_valid_i && !flush_i && (!full || pop);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers, count and sticky overflow; flush wins over everything.
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Pointers are log2(DEPTH) wide, so natural overflow implements the modulo wrap.
      if (push) begin
        mem_d[wr_ptr_q].result = result_i;
        mem_d[wr_ptr_q].mask   = vcomp_mask(result_i, element_size_i, operation_i);
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (data_valid_i && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state register; reset is treated exactly like a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset: outputs are gated while the buffer is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Outputs come only from registered head and count; stale data is masked when empty.
  always_comb begin
    data_valid_o = !empty;
    full_o       = full;
    overflow_o   = overflow_q;
    result_o     = empty ? vector_t'('0) : head.result;
    mask_o       = empty ? 4'b0000 : head.mask;
  end

endmodule
